// File: rtl/pixel_fetch_sequencer.sv
// Layer-compositing pixel fetch sequencer: walks layers top-down per pixel,
// reads each from video RAM, resolves first opaque layer, emits via valid/ready.
// Ports: clk, reset (sync, active-low), enable; counter position in
// (layer_in/x_in/y_in) and advance pulses out (next_layer/next_pixel);
// RAM read port (ram_rd_*); pixel stream out (pix_*); busy.
module pixel_fetch_sequencer #(
  parameter int NUM_LAYERS = 32,
  parameter int COLOR_W    = 16,
  parameter int H_RES      = 1920,
  parameter int V_RES      = 1080,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [4:0]         layer_in,
  input  logic [10:0]        x_in,
  input  logic [10:0]        y_in,
  output logic               next_layer,
  output logic               next_pixel,
  output logic               ram_rd_req,
  output logic [26:0]        ram_rd_addr,
  input  logic               ram_rd_valid,
  input  logic [COLOR_W:0]   ram_rd_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COLOR_W-1:0] pix_data,
  output logic [10:0]        pix_x,
  output logic [10:0]        pix_y,
  output logic               pix_first,
  output logic               pix_last,
  output logic               busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_LADV   = 3'd5;
  localparam logic [2:0] S_EMIT   = 3'd6;
  localparam logic [2:0] S_PADV   = 3'd7;

  localparam logic [4:0]  LAST_LAYER = 5'(NUM_LAYERS - 1);
  localparam logic [10:0] LAST_X     = 11'(H_RES - 1);
  localparam logic [10:0] LAST_Y     = 11'(V_RES - 1);

  logic [2:0]         state_q, state_d;
  logic [26:0]        addr_q, addr_d;
  logic [COLOR_W:0]   rdat_q, rdat_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic [10:0]        x_q, x_d;
  logic [10:0]        y_q, y_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  // Set for the SETTLE that follows a layer advance: the pixel is still
  // in flight there, so enable must not stop it.
  logic               mid_q, mid_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdat_d  = rdat_q;
    data_d  = data_q;
    x_d     = x_q;
    y_d     = y_q;
    first_d = first_q;
    last_d  = last_q;
    mid_d   = (state_q == S_LADV);
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (enable || mid_q) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
          addr_d  = '0;
          data_d  = '0;
          x_d     = '0;
          y_d     = '0;
          first_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        addr_d = {layer_in, y_in, x_in};
        if (layer_in == 5'd0) begin
          x_d = x_in;
          y_d = y_in;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ram_rd_valid) begin
          rdat_d  = ram_rd_data;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        first_d = (x_q == 11'd0) && (y_q == 11'd0);
        last_d  = (x_q == LAST_X) && (y_q == LAST_Y);
        if (rdat_q[COLOR_W]) begin
          data_d  = rdat_q[COLOR_W-1:0];
          state_d = S_EMIT;
        end else if (layer_in == LAST_LAYER) begin
          data_d  = BG_COLOR;
          state_d = S_EMIT;
        end else begin
          state_d = S_LADV;
        end
      end
      S_LADV: begin
        state_d = S_SETTLE;
      end
      S_EMIT: begin
        if (pix_ready) state_d = S_PADV;
      end
      S_PADV: begin
        state_d = S_SETTLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rdat_q  <= '0;
      data_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      mid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdat_q  <= rdat_d;
      data_q  <= data_d;
      x_q     <= x_d;
      y_q     <= y_d;
      first_q <= first_d;
      last_q  <= last_d;
      mid_q   <= mid_d;
    end
  end

  // Address is live in ISSUE so the request carries it, then held.
  assign ram_rd_req  = (state_q == S_ISSUE);
  assign ram_rd_addr = (state_q == S_ISSUE) ?
                       {layer_in, y_in, x_in} : addr_q;
  assign next_layer  = (state_q == S_LADV);
  assign next_pixel  = (state_q == S_PADV);
  assign pix_valid   = (state_q == S_EMIT);
  assign busy        = (state_q != S_IDLE);
  assign pix_data    = data_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_first   = first_q;
  assign pix_last    = last_q;

endmodule

// File: tb/tb_pixel_fetch_sequencer.sv
// Randomized scoreboard bench for pixel_fetch_sequencer with a pixel
// counter model, a variable-latency RAM model and a downstream sink.
module tb_pixel_fetch_sequencer;

  localparam int NL = 32;
  localparam int HR = 1920;
  localparam int VR = 1080;
  localparam logic [15:0] BG = 16'h0F0F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [4:0]  layer_in = '0;
  logic [10:0] x_in = '0;
  logic [10:0] y_in = '0;
  logic        next_layer, next_pixel, ram_rd_req;
  logic [26:0] ram_rd_addr;
  logic        ram_rd_valid = 1'b0;
  logic [16:0] ram_rd_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_data;
  logic [10:0] pix_x, pix_y;
  logic        pix_first, pix_last, busy;

  pixel_fetch_sequencer #(
    .NUM_LAYERS(NL), .COLOR_W(16), .H_RES(HR), .V_RES(VR),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .layer_in(layer_in), .x_in(x_in), .y_in(y_in),
    .next_layer(next_layer), .next_pixel(next_pixel),
    .ram_rd_req(ram_rd_req), .ram_rd_addr(ram_rd_addr),
    .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_first(pix_first), .pix_last(pix_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [10:0] x;
    logic [10:0] y;
    logic        f;
    logic        l;
    int          rd;
  } exp_t;

  exp_t        exp_q[$];
  int          kk[$];
  logic [15:0] col[$];
  int          start_x = 0;
  int          start_y = 0;
  int          exp_reads = 0;
  int          req_total = 0;
  int          rdy_mode = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          pn = 0;

  // Reference: pixel n of a run sits start+n in raster order; its colour
  // is the first opaque layer k, or background if k >= NL.
  task automatic add_px(int k, logic [15:0] c);
    int n;
    int p;
    exp_t e;
    n = kk.size();
    p = (start_y * HR + start_x + n) % (HR * VR);
    e.x = 11'(p % HR);
    e.y = 11'(p / HR);
    e.d = (k < NL) ? c : BG;
    e.f = (p == 0);
    e.l = (p == HR * VR - 1);
    e.rd = (k < NL) ? k + 1 : NL;
    kk.push_back(k);
    col.push_back(c);
    exp_q.push_back(e);
    exp_reads += e.rd;
  endtask

  task automatic add_rand();
    int k;
    k = ($urandom_range(5, 0) == 0) ? NL : int'($urandom_range(6, 0));
    add_px(k, 16'($urandom));
  endtask

  task automatic new_run(int sx, int sy);
    exp_q.delete();
    kk.delete();
    col.delete();
    start_x = sx;
    start_y = sy;
    exp_reads = 0;
  endtask

  task automatic zeros(string nm);
    chk(nm, {busy, pix_valid, ram_rd_req, next_layer, next_pixel,
             pix_first, pix_last, pix_data, pix_x, pix_y}, '0);
    chk({nm, "_addr"}, ram_rd_addr, '0);
  endtask

  // Counter + RAM + sink driver: samples at negedge, drives at posedge+1.
  initial begin : drv
    logic s_req, s_nl, s_np, s_rst, s_v, s_acc;
    logic [16:0] pend;
    int cl, cx, cy, rem, vcnt;
    cl = 0; cx = 0; cy = 0; rem = 0; vcnt = 0;
    pend = '0;
    forever begin
      @(negedge clk);
      s_req = ram_rd_req;
      s_nl  = next_layer;
      s_np  = next_pixel;
      s_rst = reset;
      s_v   = pix_valid;
      s_acc = pix_valid && pix_ready;
      if (s_req && s_rst) begin
        req_total++;
        chk("rd_addr", 64'(ram_rd_addr), 64'({5'(cl), 11'(cy), 11'(cx)}));
        if (pn >= kk.size() || cl > kk[pn])
          fail_now($sformatf("rd_extra pixel %0d layer %0d", pn, cl));
        if (pn < kk.size() && cl == kk[pn])
          pend = {1'b1, col[pn]};
        else
          pend = {1'b0, 16'($urandom)};
      end
      if (s_v && !s_acc) vcnt++;
      else vcnt = 0;
      @(posedge clk);
      #1;
      if (!s_rst) begin
        cl = 0; cx = start_x; cy = start_y; pn = 0;
      end else begin
        if (s_nl) cl++;
        if (s_np) begin
          cl = 0;
          pn++;
          cx++;
          if (cx == HR) begin
            cx = 0;
            cy++;
            if (cy == VR) cy = 0;
          end
        end
      end
      layer_in = 5'(cl);
      x_in = 11'(cx);
      y_in = 11'(cy);
      if (s_req && s_rst) rem = int'($urandom_range(lat_max, lat_min));
      if (rem > 0) begin
        rem--;
        ram_rd_valid = (rem == 0);
      end else begin
        ram_rd_valid = 1'b0;
      end
      ram_rd_data = ram_rd_valid ? pend : 17'($urandom);
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'($urandom_range(1, 0));
        default: pix_ready = (vcnt >= 5);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted pixel.
  initial begin : mon
    logic prev_pulse, acc_prev, hold_v;
    logic [39:0] held, cur;
    int rd_cnt, nl_cnt;
    exp_t e;
    prev_pulse = 0; acc_prev = 0; hold_v = 0; held = '0;
    rd_cnt = 0; nl_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_pulse = 0; acc_prev = 0; hold_v = 0;
        rd_cnt = 0; nl_cnt = 0;
        continue;
      end
      if (next_layer || next_pixel)
        chk("pulse_excl", {next_layer & next_pixel, prev_pulse}, 0);
      if (acc_prev || next_pixel)
        chk("np_after_accept", next_pixel, acc_prev);
      prev_pulse = next_layer | next_pixel;
      if (ram_rd_req) rd_cnt++;
      if (next_layer) nl_cnt++;
      cur = {pix_data, pix_x, pix_y, pix_first, pix_last};
      if (hold_v) chk("emit_hold", {pix_valid, cur}, {1'b1, held});
      acc_prev = 0;
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pixel");
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", pix_data, e.d);
          chk("pix_xy", {pix_x, pix_y}, {e.x, e.y});
          chk("pix_first_last", {pix_first, pix_last}, {e.f, e.l});
          chk("reads_per_pixel", rd_cnt, e.rd);
          chk("next_layer_count", nl_cnt, e.rd - 1);
        end
        rd_cnt = 0;
        nl_cnt = 0;
        acc_prev = 1;
      end
      hold_v = pix_valid && !pix_ready;
      held = cur;
    end
  end

  task automatic start_run();
    @(posedge clk);
    #2;
    enable = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #2;
    zeros("reset_state");
    req_total = 0;
    reset = 1'b1;
  endtask

  task automatic finish_run(string nm);
    int last;
    bit got;
    last = kk.size() - 1;
    got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (ram_rd_req && pn == last) got = 1;
    end
    if (!got) fail_now({nm, "_last_pixel_timeout"});
    @(posedge clk);
    #2;
    enable = 1'b0;
    got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) got = 1;
    end
    repeat (4) @(posedge clk);
    #2;
    chk({nm, "_left_pixels"}, exp_q.size(), 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_req_total"}, req_total, exp_reads);
    zeros({nm, "_idle"});
  endtask

  initial begin : main
    int first_req, first_np;
    bit got;

    // Run 1: directed opening pixels then random.
    new_run(0, 0);
    add_px(0, 16'hABCD);
    add_px(3, 16'h1234);
    add_px(NL, 16'h5555);
    repeat (9) add_rand();
    add_px(5, 16'h2468);
    rdy_mode = 0;
    lat_min = 1;
    lat_max = 1;
    start_run();
    first_req = -1;
    first_np = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #2;
      if (ram_rd_req && first_req < 0) first_req = i;
      if (next_pixel && first_np < 0) first_np = i;
    end
    chk("first_req_cycle", first_req, 2);
    chk("first_np_cycle", first_np, 6);
    rdy_mode = 1;
    lat_max = 3;
    finish_run("run1");

    // Run 2: frame wrap, ready held low 5 cycles per pixel.
    new_run(1918, 1079);
    add_rand();
    add_px(1, 16'h0BAD);
    add_px(0, 16'hC0DE);
    add_px(3, 16'h4321);
    rdy_mode = 2;
    lat_min = 1;
    lat_max = 3;
    start_run();
    finish_run("run2");

    // Run 3: reset asserted while waiting on RAM, stale data ignored.
    new_run(5, 7);
    add_px(0, 16'h7777);
    rdy_mode = 1;
    lat_min = 2;
    lat_max = 2;
    start_run();
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (ram_rd_req) got = 1;
    end
    if (!got) fail_now("run3_req_timeout");
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #2;
    zeros("reset_mid_wait");
    new_run(5, 7);
    repeat (2) add_rand();
    add_px(4, 16'h9999);
    req_total = 0;
    lat_min = 1;
    lat_max = 3;
    reset = 1'b1;
    first_req = -1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #2;
      if (ram_rd_req && first_req < 0) first_req = i;
    end
    chk("req_after_reset", first_req, 2);
    finish_run("run3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
